// File: rtl/input_conditioner_bank_pkg.sv
// Board-level defaults for the input conditioner bank and the channel
// assignment seen by the shift-register wrapper.
package input_conditioner_bank_pkg;

    localparam int DEFAULT_CHANNELS    = 3;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_WAIT_CYCLES = 3;

    // Channel roles as wired on the board
    localparam int LOAD_BTN   = 0;
    localparam int SERIAL_SW  = 1;
    localparam int CLKEDGE_SW = 2;

endpackage

// File: rtl/input_conditioner_bank_channel.sv
// One conditioned input: synchronizer chain, debounce counter and
// registered level / edge / settling outputs.
module input_conditioner
    import input_conditioner_bank_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic conditioned,
    output logic positive_edge,
    output logic negative_edge,
    output logic settling
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [SYNC_STAGES-1:0] sync_chain_r;
    logic                   sync_s;
    logic [CNT_W-1:0]       count_r;
    logic [CNT_W-1:0]       count_next_s;
    logic                   cond_r;
    logic                   cond_next_s;
    logic                   pos_r;
    logic                   pos_next_s;
    logic                   neg_r;
    logic                   neg_next_s;
    logic                   settle_r;
    logic                   settle_next_s;

    assign sync_s = sync_chain_r[SYNC_STAGES-1];

    // Synchronizer chain: the raw input enters at bit 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_chain_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_chain_r <= {sync_chain_r[SYNC_STAGES-2:0], noisy};
        end
    end

    // Debounce decision: count persistent mismatches, accept on the last one
    always_comb begin
        count_next_s = count_r;
        cond_next_s  = cond_r;
        pos_next_s   = 1'b0;
        neg_next_s   = 1'b0;
        if (sync_s == cond_r) begin
            count_next_s = CNT_ZERO;
        end else if (count_r == CNT_LAST) begin
            count_next_s = CNT_ZERO;
            cond_next_s  = sync_s;
            pos_next_s   = sync_s;
            neg_next_s   = ~sync_s;
        end else begin
            count_next_s = count_r + CNT_ONE;
        end
        settle_next_s = (count_next_s != CNT_ZERO);
    end

    // Debounce state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= CNT_ZERO;
            cond_r   <= 1'b0;
            pos_r    <= 1'b0;
            neg_r    <= 1'b0;
            settle_r <= 1'b0;
        end else begin
            count_r  <= count_next_s;
            cond_r   <= cond_next_s;
            pos_r    <= pos_next_s;
            neg_r    <= neg_next_s;
            settle_r <= settle_next_s;
        end
    end

    assign conditioned   = cond_r;
    assign positive_edge = pos_r;
    assign negative_edge = neg_r;
    assign settling      = settle_r;

endmodule

// File: rtl/input_conditioner_bank.sv
// Bank of independent input conditioners; channel i of every output bus
// belongs to noisy[i].
module input_conditioner_bank
    import input_conditioner_bank_pkg::*;
#(
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] noisy,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positive_edge,
    output logic [CHANNELS-1:0] negative_edge,
    output logic [CHANNELS-1:0] settling
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        input_conditioner #(
            .SYNC_STAGES (SYNC_STAGES),
            .WAIT_CYCLES (WAIT_CYCLES)
        ) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .noisy         (noisy[ch]),
            .conditioned   (conditioned[ch]),
            .positive_edge (positive_edge[ch]),
            .negative_edge (negative_edge[ch]),
            .settling      (settling[ch])
        );
    end

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Directed bench for input_conditioner_bank with a window-based reference
// model checked every cycle plus hand-computed literal expectations.
module tb_input_conditioner_bank;

    localparam int CH = 3;
    localparam int SS = 2;
    localparam int WC = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] noisy = 3'b000;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] positive_edge;
    logic [CH-1:0] negative_edge;
    logic [CH-1:0] settling;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [CH-1:0] m_cond   = 3'b000;
    logic [CH-1:0] m_pos    = 3'b000;
    logic [CH-1:0] m_neg    = 3'b000;
    logic [CH-1:0] m_settle = 3'b000;
    logic [CH-1:0] samp[$];
    logic [CH-1:0] sq[$];

    input_conditioner_bank #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .noisy         (noisy),
        .conditioned   (conditioned),
        .positive_edge (positive_edge),
        .negative_edge (negative_edge),
        .settling      (settling)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // The level accepted at an edge is the value seen by the synchronizer output
    // SS edges earlier; a change is accepted once the last WC synced values all
    // disagree with the current level.
    task automatic model_step();
        logic [CH-1:0] s;
        int k;
        int idx;
        int run;
        bit all_diff;
        bit v;
        k = samp.size();
        s = (k >= SS) ? samp[k-SS] : 3'b000;
        samp.push_back(noisy);
        sq.push_back(s);
        m_pos = 3'b000;
        m_neg = 3'b000;
        for (int ch = 0; ch < CH; ch++) begin
            all_diff = 1'b1;
            for (int j = 0; j < WC; j++) begin
                idx = sq.size() - 1 - j;
                v = (idx >= 0) ? sq[idx][ch] : 1'b0;
                if (v == m_cond[ch]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_cond[ch] = ~m_cond[ch];
                m_pos[ch]  = m_cond[ch];
                m_neg[ch]  = ~m_cond[ch];
            end
            run = 0;
            for (int j = 0; j < WC; j++) begin
                idx = sq.size() - 1 - j;
                if (idx < 0) break;
                if (sq[idx][ch] != m_cond[ch]) run++;
                else break;
            end
            m_settle[ch] = (run != 0);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cond   = 3'b000;
                m_pos    = 3'b000;
                m_neg    = 3'b000;
                m_settle = 3'b000;
                samp.delete();
                sq.delete();
            end else begin
                model_step();
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_conditioned", conditioned, m_cond);
            check("model_positive_edge", positive_edge, m_pos);
            check("model_negative_edge", negative_edge, m_neg);
            check("model_settling", settling, m_settle);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [5:0] bounce_pat;

    initial begin
        // Reset held with all inputs high, then released
        noisy = 3'b111;
        step(3);
        check("rst_conditioned", conditioned, 3'b000);
        check("rst_positive_edge", positive_edge, 3'b000);
        check("rst_negative_edge", negative_edge, 3'b000);
        check("rst_settling", settling, 3'b000);
        rst_n = 1'b1;
        step(3);
        check("rel_settling_e2", settling, 3'b111);
        check("rel_conditioned_e2", conditioned, 3'b000);
        step(1);
        check("rel_settling_e3", settling, 3'b111);
        step(1);
        check("rel_conditioned_e4", conditioned, 3'b111);
        check("rel_positive_edge_e4", positive_edge, 3'b111);
        check("rel_settling_e4", settling, 3'b000);
        step(1);
        check("rel_positive_edge_e5", positive_edge, 3'b000);

        // All channels fall
        noisy = 3'b000;
        step(4);
        check("fall_negative_edge_e3", negative_edge, 3'b000);
        step(1);
        check("fall_negative_edge_e4", negative_edge, 3'b111);
        check("fall_conditioned_e4", conditioned, 3'b000);
        step(4);

        // Clean step on channel 0
        noisy = 3'b001;
        step(4);
        check("step_conditioned_e3", conditioned, 3'b000);
        step(1);
        check("step_positive_edge_e4", positive_edge, 3'b001);
        check("step_conditioned_e4", conditioned, 3'b001);
        step(1);
        check("step_positive_edge_e5", positive_edge, 3'b000);
        step(3);
        noisy = 3'b000;
        step(4);
        check("step_negative_edge_e3", negative_edge, 3'b000);
        step(1);
        check("step_negative_edge_e4", negative_edge, 3'b001);
        step(4);

        // Two-cycle glitch on channel 1
        noisy = 3'b010;
        step(2);
        noisy = 3'b000;
        step(2);
        check("glitch_settling_e3", settling, 3'b010);
        step(1);
        check("glitch_settling_e4", settling, 3'b000);
        step(4);
        check("glitch_conditioned", conditioned, 3'b000);

        // Bounce on channel 2: 1,1,0,1,1,1 then held high
        bounce_pat = 6'b111011;
        for (int i = 0; i < 6; i++) begin
            noisy = {bounce_pat[i], 2'b00};
            step(1);
        end
        step(1);
        check("bounce_conditioned_e6", conditioned, 3'b000);
        check("bounce_settling_e6", settling, 3'b100);
        step(1);
        check("bounce_positive_edge_e7", positive_edge, 3'b100);
        check("bounce_conditioned_e7", conditioned, 3'b100);
        noisy = 3'b000;
        step(8);

        // Simultaneous rise on channels 0 and 2
        noisy = 3'b101;
        step(4);
        check("simul_positive_edge_e3", positive_edge, 3'b000);
        step(1);
        check("simul_positive_edge_e4", positive_edge, 3'b101);
        check("simul_negative_edge_e4", negative_edge, 3'b000);
        step(1);
        check("simul_positive_edge_e5", positive_edge, 3'b000);
        noisy = 3'b000;
        step(8);

        // Asynchronous reset while channel 0 is mid-debounce
        noisy = 3'b001;
        step(4);
        check("mid_settling_before_rst", settling, 3'b001);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_settling", settling, 3'b000);
        check("mid_rst_conditioned", conditioned, 3'b000);
        check("mid_rst_positive_edge", positive_edge, 3'b000);
        step(2);
        rst_n = 1'b1;
        step(4);
        check("mid_rel_conditioned_e3", conditioned, 3'b000);
        step(1);
        check("mid_rel_conditioned_e4", conditioned, 3'b001);
        check("mid_rel_positive_edge_e4", positive_edge, 3'b001);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
